// File: rtl/hazard_ctrl_if.sv
// Pipeline sequencing bundle between the core datapath and hazard_ctrl.
// The pipeline drives hazard sources (master); the controller returns stall/flush controls (slave).
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             IDEX_memRead;
    logic [4:0]       IDEX_RD;
    logic [4:0]       IFID_RS1;
    logic [4:0]       IFID_RS2;
    logic             IFID_useRs1;
    logic             IFID_useRs2;
    logic             EX_redirect;
    logic             imem_ready;
    logic             dmem_req;
    logic             dmem_ready;
    logic             halt_req;
    logic             resume;

    logic             PC_stall;
    logic             IFID_stall;
    logic             IDEX_stall;
    logic             EXMEM_stall;
    logic             IFID_flush;
    logic             IDEX_flush;
    logic             MEMWB_flush;
    logic [1:0]       state;
    logic             mem_fault;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output IDEX_memRead, IDEX_RD, IFID_RS1, IFID_RS2, IFID_useRs1, IFID_useRs2,
        output EX_redirect, imem_ready, dmem_req, dmem_ready, halt_req, resume,
        input  PC_stall, IFID_stall, IDEX_stall, EXMEM_stall,
        input  IFID_flush, IDEX_flush, MEMWB_flush,
        input  state, mem_fault, stall_cnt, flush_cnt
    );

    modport slave (
        input  IDEX_memRead, IDEX_RD, IFID_RS1, IFID_RS2, IFID_useRs1, IFID_useRs2,
        input  EX_redirect, imem_ready, dmem_req, dmem_ready, halt_req, resume,
        output PC_stall, IFID_stall, IDEX_stall, EXMEM_stall,
        output IFID_flush, IDEX_flush, MEMWB_flush,
        output state, mem_fault, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline sequencing controller: load-use/redirect/imem/dmem/halt handling,
// dmem timeout watchdog and saturating stall/flush performance counters.
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        StRun     = 2'b00,
        StMemWait = 2'b01,
        StHalted  = 2'b10,
        StFault   = 2'b11
    } state_e;

    localparam logic [16:0]      Timeout = 17'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntMax  = '1;

    state_e           state_q, state_d;
    logic [15:0]      wait_cnt_q, wait_cnt_d;
    logic             mem_fault_q, mem_fault_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic        load_use;
    logic        freeze;
    logic        advance;
    logic [16:0] wait_next;
    logic        pc_stall, ifid_stall, idex_stall, exmem_stall;
    logic        ifid_flush, idex_flush, memwb_flush;

    // Register 0 is hardwired zero, so a load targeting it never creates a dependency.
    assign load_use = hz.IDEX_memRead && (hz.IDEX_RD != 5'd0) &&
                      ((hz.IFID_useRs1 && (hz.IFID_RS1 == hz.IDEX_RD)) ||
                       (hz.IFID_useRs2 && (hz.IFID_RS2 == hz.IDEX_RD)));

    assign wait_next = {1'b0, wait_cnt_q} + 17'd1;

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_fault_d = mem_fault_q;
        freeze      = 1'b0;
        advance     = 1'b0;

        unique case (state_q)
            StRun: begin
                if (hz.dmem_req && !hz.dmem_ready) begin
                    freeze = 1'b1;
                    // This RUN cycle already counts as the first wait cycle.
                    if (Timeout <= 17'd1) begin
                        state_d     = StFault;
                        mem_fault_d = 1'b1;
                    end else begin
                        state_d    = StMemWait;
                        wait_cnt_d = 16'd1;
                    end
                end else if (hz.halt_req) begin
                    freeze  = 1'b1;
                    state_d = StHalted;
                end else begin
                    advance = 1'b1;
                end
            end
            StMemWait: begin
                if (!hz.dmem_ready) begin
                    freeze = 1'b1;
                    if (wait_next >= Timeout) begin
                        state_d     = StFault;
                        mem_fault_d = 1'b1;
                        wait_cnt_d  = 16'd0;
                    end else begin
                        wait_cnt_d = wait_next[15:0];
                    end
                end else begin
                    advance    = 1'b1;
                    state_d    = StRun;
                    wait_cnt_d = 16'd0;
                end
            end
            StHalted: begin
                freeze = 1'b1;
                if (hz.resume) begin
                    state_d = StRun;
                end
            end
            StFault: begin
                freeze = 1'b1;
            end
        endcase
    end

    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        idex_stall  = 1'b0;
        exmem_stall = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        memwb_flush = 1'b0;
        if (freeze) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
            memwb_flush = 1'b1;
        end else if (advance) begin
            if (hz.EX_redirect) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (load_use) begin
                // The load moves on to MEM, so one bubble resolves the dependency.
                pc_stall   = 1'b1;
                ifid_stall = 1'b1;
                idex_flush = 1'b1;
            end else if (!hz.imem_ready) begin
                pc_stall   = 1'b1;
                ifid_flush = 1'b1;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (pc_stall && (stall_cnt_q != CntMax)) begin
            stall_cnt_d = stall_cnt_q + CntOne;
        end
        if (idex_flush && (flush_cnt_q != CntMax)) begin
            flush_cnt_d = flush_cnt_q + CntOne;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StRun;
            wait_cnt_q  <= 16'd0;
            mem_fault_q <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_fault_q <= mem_fault_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.PC_stall    = pc_stall;
    assign hz.IFID_stall  = ifid_stall;
    assign hz.IDEX_stall  = idex_stall;
    assign hz.EXMEM_stall = exmem_stall;
    assign hz.IFID_flush  = ifid_flush;
    assign hz.IDEX_flush  = idex_flush;
    assign hz.MEMWB_flush = memwb_flush;
    assign hz.state       = state_q;
    assign hz.mem_fault   = mem_fault_q;
    assign hz.stall_cnt   = stall_cnt_q;
    assign hz.flush_cnt   = flush_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a short timeout and narrow counters so
// fault entry and counter saturation are reachable in a few cycles.
module tb_hazard_ctrl;
    localparam int unsigned Tmo  = 4;
    localparam int unsigned CntW = 4;

    // Control vector order: PC_s, IFID_s, IDEX_s, EXMEM_s, IFID_f, IDEX_f, MEMWB_f
    localparam logic [6:0] CtlNone   = 7'b0000_000;
    localparam logic [6:0] CtlLdUse  = 7'b1100_010;
    localparam logic [6:0] CtlRedir  = 7'b0000_110;
    localparam logic [6:0] CtlImem   = 7'b1000_100;
    localparam logic [6:0] CtlFreeze = 7'b1111_001;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   failures = 0;

    hazard_ctrl_if #(.CNT_W(CntW)) hz ();

    hazard_ctrl #(
        .MEM_TIMEOUT(Tmo),
        .CNT_W      (CntW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .hz   (hz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_ctl(input string tag, input logic [6:0] exp);
        logic [6:0] obs;
        obs = {hz.PC_stall, hz.IFID_stall, hz.IDEX_stall, hz.EXMEM_stall,
               hz.IFID_flush, hz.IDEX_flush, hz.MEMWB_flush};
        check(tag, 32'(obs), 32'(exp));
    endtask

    task automatic idle();
        hz.IDEX_memRead = 1'b0;
        hz.IDEX_RD      = 5'd0;
        hz.IFID_RS1     = 5'd0;
        hz.IFID_RS2     = 5'd0;
        hz.IFID_useRs1  = 1'b0;
        hz.IFID_useRs2  = 1'b0;
        hz.EX_redirect  = 1'b0;
        hz.imem_ready   = 1'b1;
        hz.dmem_req     = 1'b0;
        hz.dmem_ready   = 1'b0;
        hz.halt_req     = 1'b0;
        hz.resume       = 1'b0;
    endtask

    task automatic load_use_rs1(input logic [4:0] rd, input logic [4:0] rs1, input logic use1);
        hz.IDEX_memRead = 1'b1;
        hz.IDEX_RD      = rd;
        hz.IFID_RS1     = rs1;
        hz.IFID_useRs1  = use1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        idle();
        #2 rst_n = 1'b0;
        #1;
        check("rst_state", 32'(hz.state), 32'd0);
        check("rst_fault", 32'(hz.mem_fault), 32'd0);
        check("rst_stall_cnt", 32'(hz.stall_cnt), 32'd0);
        check("rst_flush_cnt", 32'(hz.flush_cnt), 32'd0);
        check_ctl("rst_ctl", CtlNone);
        release_reset();

        // Load-use on rs1: exactly one bubble.
        load_use_rs1(5'd5, 5'd5, 1'b1);
        #1 check_ctl("lu_rs1", CtlLdUse);
        step();
        idle();
        #1 check_ctl("lu_after", CtlNone);
        check("lu_stall_cnt", 32'(hz.stall_cnt), 32'd1);
        check("lu_flush_cnt", 32'(hz.flush_cnt), 32'd1);

        load_use_rs1(5'd0, 5'd0, 1'b1);
        #1 check_ctl("lu_rd0", CtlNone);
        step();
        load_use_rs1(5'd5, 5'd5, 1'b0);
        #1 check_ctl("lu_nouse", CtlNone);
        step();
        idle();
        hz.IDEX_memRead = 1'b1;
        hz.IDEX_RD      = 5'd9;
        hz.IFID_RS2     = 5'd9;
        hz.IFID_useRs2  = 1'b1;
        #1 check_ctl("lu_rs2", CtlLdUse);
        step();
        check("lu_rs2_stall_cnt", 32'(hz.stall_cnt), 32'd2);

        // Redirect wins over load-use.
        idle();
        load_use_rs1(5'd5, 5'd5, 1'b1);
        hz.EX_redirect = 1'b1;
        #1 check_ctl("redir_lu", CtlRedir);
        step();
        check("redir_flush_cnt", 32'(hz.flush_cnt), 32'd3);
        check("redir_stall_cnt", 32'(hz.stall_cnt), 32'd2);

        idle();
        hz.imem_ready = 1'b0;
        #1 check_ctl("imem_wait", CtlImem);
        step();
        load_use_rs1(5'd7, 5'd7, 1'b1);
        #1 check_ctl("imem_lu", CtlLdUse);
        step();
        check("imem_stall_cnt", 32'(hz.stall_cnt), 32'd4);
        check("imem_flush_cnt", 32'(hz.flush_cnt), 32'd4);

        // dmem low for 3 cycles; ready arrives exactly at the timeout count.
        idle();
        hz.dmem_req = 1'b1;
        #1 check_ctl("dm_freeze0", CtlFreeze);
        check("dm_state0", 32'(hz.state), 32'd0);
        step();
        check("dm_state1", 32'(hz.state), 32'd1);
        check_ctl("dm_freeze1", CtlFreeze);
        step();
        check("dm_state2", 32'(hz.state), 32'd1);
        step();
        check("dm_state3", 32'(hz.state), 32'd1);
        hz.dmem_ready = 1'b1;
        #1 check_ctl("dm_ready", CtlNone);
        step();
        check("dm_back_run", 32'(hz.state), 32'd0);
        check("dm_no_fault", 32'(hz.mem_fault), 32'd0);
        check("dm_stall_cnt", 32'(hz.stall_cnt), 32'd7);

        hz.dmem_ready = 1'b1;
        #1 check_ctl("dm_zero_wait", CtlNone);
        step();
        check("dm_zero_state", 32'(hz.state), 32'd0);

        // Timeout: FAULT after 4 wait cycles, sticky across resume.
        hz.dmem_ready = 1'b0;
        step();
        step();
        step();
        check("tmo_pre_state", 32'(hz.state), 32'd1);
        step();
        check("tmo_state", 32'(hz.state), 32'd3);
        check("tmo_fault", 32'(hz.mem_fault), 32'd1);
        idle();
        hz.resume = 1'b1;
        step();
        step();
        check("tmo_sticky", 32'(hz.state), 32'd3);
        check_ctl("tmo_freeze", CtlFreeze);
        hz.resume = 1'b0;
        rst_n = 1'b0;
        #1;
        check("tmo_rst_state", 32'(hz.state), 32'd0);
        check("tmo_rst_fault", 32'(hz.mem_fault), 32'd0);
        check("tmo_rst_cnt", 32'(hz.stall_cnt), 32'd0);
        release_reset();

        // Halt with a simultaneous resume: halt wins; resume after 10 halted cycles.
        hz.halt_req = 1'b1;
        hz.resume   = 1'b1;
        #1 check_ctl("halt_ctl", CtlFreeze);
        step();
        hz.halt_req = 1'b0;
        hz.resume   = 1'b0;
        check("halt_state", 32'(hz.state), 32'd2);
        for (int i = 0; i < 9; i++) begin
            step();
        end
        check("halt_hold", 32'(hz.state), 32'd2);
        check_ctl("halt_freeze", CtlFreeze);
        hz.resume = 1'b1;
        step();
        hz.resume = 1'b0;
        check("halt_resume", 32'(hz.state), 32'd0);
        check("halt_stall_cnt", 32'(hz.stall_cnt), 32'd11);
        check("halt_flush_cnt", 32'(hz.flush_cnt), 32'd0);

        // Long halt drives the 4-bit stall counter past its maximum.
        hz.halt_req = 1'b1;
        step();
        hz.halt_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
        end
        check("sat_stall_cnt", 32'(hz.stall_cnt), 32'd15);
        rst_n = 1'b0;
        #1;
        check("rst_halted_state", 32'(hz.state), 32'd0);
        check("rst_halted_cnt", 32'(hz.stall_cnt), 32'd0);
        release_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage core. Each cycle it decides whether the pipeline registers load, stall or take a bubble. Inputs are load-use hazards, taken branches/jumps, instruction- and data-memory wait handshakes, and halt/resume requests. It sits beside the forwarding logic, which stays combinational and handles everything except load-use. It also keeps a timeout watchdog and saturating performance counters.

## Interface
- MEM_TIMEOUT, 255: maximum consecutive dmem wait cycles before the fault trap (1..65535).
- CNT_W, 32: width of the performance counters.
- clk  in  1  core clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- IDEX_memRead  in  1  instruction in EX is a load
- IDEX_RD  in  5  destination register of the instruction in EX
- IFID_RS1, IFID_RS2  in  5 each  source registers of the instruction in ID
- IFID_useRs1, IFID_useRs2  in  1 each  ID instruction actually reads rs1 / rs2
- EX_redirect  in  1  branch taken or jump resolved in EX
- imem_ready  in  1  instruction fetch data valid this cycle
- dmem_req  in  1  MEM stage has a load/store in flight
- dmem_ready  in  1  data memory completes the MEM-stage access this cycle
- halt_req  in  1  ebreak/halt retiring in WB
- resume  in  1  debug resume pulse
- PC_stall, IFID_stall, IDEX_stall, EXMEM_stall  out  1 each  hold the register
- IFID_flush, IDEX_flush, MEMWB_flush  out  1 each  load a bubble (NOP, all write enables 0)
- state  out  2  00 RUN, 01 MEM_WAIT, 10 HALTED, 11 FAULT
- mem_fault  out  1  sticky dmem timeout flag
- stall_cnt, flush_cnt  out  CNT_W each  saturating counters

## Operation
- The FSM state is registered. All stall and flush outputs are combinational from the current state and inputs, so the pipeline registers use them on the same edge.
- **RUN**, with conditions evaluated in the priority order below:
  1. dmem_req && !dmem_ready: freeze. PC, IFID, IDEX and EXMEM stall; MEMWB_flush. Next state is MEM_WAIT, and the wait counter is set to 1.
  2. halt_req: all four stalls asserted and MEMWB_flush. Next state is HALTED.
  3. EX_redirect: IFID_flush and IDEX_flush. The PC loads the target with no stall, and any load-use in the same cycle is ignored.
  4. Load-use: IDEX_memRead && IDEX_RD!=0 && ((IFID_useRs1 && IFID_RS1==IDEX_RD) || (IFID_useRs2 && IFID_RS2==IDEX_RD)). PC_stall, IFID_stall and IDEX_flush are asserted for exactly one cycle, because the load advances to MEM.
  5. !imem_ready: PC_stall and IFID_flush. The rest of the pipeline advances. This is combined with 4 only when 4 is absent; if 4 is active, 4 wins and IFID holds.
- **MEM_WAIT**:
  - Behaves as a full freeze (as in RUN rule 1) while !dmem_ready.
  - On dmem_ready: no stall, the pipeline advances, and the state returns to RUN. Redirect, load-use and imem rules apply that cycle as in RUN.
  - The wait counter increments each waiting cycle. When it reaches MEM_TIMEOUT with dmem_ready still low, the state goes to FAULT and mem_fault is set.
- **HALTED**:
  - Full freeze with MEMWB_flush.
  - A resume pulse returns the state to RUN on the next edge. halt_req is ignored while HALTED.
- **FAULT**:
  - Full freeze with MEMWB_flush.
  - FAULT is left only by reset. mem_fault is cleared only by reset.
- **Counters**:
  - stall_cnt increments every cycle PC_stall is 1.
  - flush_cnt increments every cycle IDEX_flush is 1.
  - Both saturate at all-ones and never wrap.
- A register index of 0 never causes a load-use hazard.

## Timing
- Reset (asynchronous assert, synchronous deassert) sets:
  - state = RUN and wait counter = 0;
  - stall_cnt = flush_cnt = 0 and mem_fault = 0;
  - all stall and flush outputs = 0, unless the inputs demand otherwise in RUN.
- Reset asserted mid-MEM_WAIT or mid-HALTED returns to RUN immediately. The counters clear.
- Load-use costs exactly 1 bubble. A redirect costs 2 bubbles (IF and ID).
- A dmem access completing on the first cycle (dmem_ready with dmem_req) costs 0 stall cycles. Each low-ready cycle costs 1 stall cycle.
- The wait counter is 16 bits. FAULT is entered on the edge ending the MEM_TIMEOUT-th consecutive wait cycle.
- If dmem_ready and the timeout coincide, dmem_ready wins and no fault is raised.
- resume and halt_req asserted in the same RUN cycle: halt wins. resume is level-insensitive outside HALTED.

## Test plan
- Load-use: EX holds lw with RD=5; ID holds add with RS1=5 and useRs1=1 -> PC_stall=IFID_stall=IDEX_flush=1 for one cycle, then 0; stall_cnt=1, flush_cnt=1.
- Same stimulus with RD=0, or with useRs1=0 -> no stall and no flush.
- Redirect together with load-use -> IFID_flush=IDEX_flush=1 and PC_stall=0; flush_cnt +1.
- dmem_req=1 with dmem_ready low for 3 cycles, then high -> 3 frozen cycles with MEMWB_flush; state sequence RUN, MEM_WAIT ×3, RUN; stall_cnt=3.
- MEM_TIMEOUT=4 with dmem_ready held low -> state=FAULT after 4 wait cycles and mem_fault=1; the state stays FAULT with resume; rst_n low clears it to RUN.
- halt_req pulse -> HALTED with full freeze; resume after 10 cycles -> RUN next edge; stall_cnt=11. Also preset stall_cnt to all-ones via a long halt -> no wrap.
